// File: rtl/sorter_batch_ctrl.sv
// sorter_batch_ctrl: batches an elastic valid/ready stream into groups of up to
// N elements for the streaming top-N sorter. Each accepted element is forwarded
// as a one-cycle data_i/data_i_v pulse. After the final element, flush is held
// for FLUSH_CYCLES so the sorter drains the batch in order. One gap cycle follows
// before the next batch is accepted.
// Optional feature: define SORTER_BATCH_TIMEOUT_EN to force-flush a partial batch
// after TIMEOUT idle cycles.
module sorter_batch_ctrl #(
    parameter int WIDTH        = 8,
    parameter int N            = 22,
    parameter int FLUSH_CYCLES = 44,
    parameter int TIMEOUT      = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         sort_data,
    output logic                     sort_valid,
    output logic                     sort_flush,
    output logic                     batch_done,
    output logic [$clog2(N+1)-1:0]   batch_len
);

    localparam int CW = $clog2(N+1);
    localparam int DW = $clog2(FLUSH_CYCLES+1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        DRAIN = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] drain;
    logic          accept;
    logic          timeout_hit;
    logic          close_batch;
    logic          drain_end;

    // in_ready is held low while rst is asserted so nothing is taken during reset.
    assign in_ready    = (state == LOAD) && !rst;
    assign accept      = in_valid && in_ready;
    // in_last on the Nth element is the same event as reaching N: one close, not two.
    assign close_batch = (accept && (in_last || (cnt == CW'(N-1)))) || timeout_hit;
    // Drain ends after the last flush cycle has been presented (flush high, counter spent).
    assign drain_end   = (state == DRAIN) && sort_flush && (drain == '0);

`ifdef SORTER_BATCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] idle;

    // A partial batch that has seen TIMEOUT cycles without an accept is closed.
    assign timeout_hit = (state == LOAD) && (cnt != '0) && !accept
                         && (idle == TW'(TIMEOUT-1));

    // Idle timer: counts non-accept cycles of a started batch, cleared on accept or drain entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle <= '0;
        end else if ((state != LOAD) || accept || timeout_hit) begin
            idle <= '0;
        end else if (cnt != '0) begin
            idle <= idle + 1'b1;
        end
    end
`else
    // No timer: a partial batch waits for in_last or the Nth element (term folds to 0).
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: LOAD -> DRAIN on batch close, DRAIN -> GAP after flush window, GAP -> LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (close_batch) state_nxt = DRAIN;
            DRAIN:   if (drain_end)   state_nxt = GAP;
            GAP:     state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Element forwarding and batch element count; count is cleared in the gap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sort_data  <= '0;
            sort_valid <= 1'b0;
            cnt        <= '0;
        end else begin
            sort_valid <= accept;
            if (accept) begin
                sort_data <= in_data;
                cnt       <= cnt + 1'b1;
            end else if (state == GAP) begin
                cnt <= '0;
            end
        end
    end

    // Flush window: the first DRAIN cycle carries the final data pulse, then flush runs
    // FLUSH_CYCLES cycles with batch_done/batch_len on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain      <= '0;
            sort_flush <= 1'b0;
            batch_done <= 1'b0;
            batch_len  <= '0;
        end else begin
            batch_done <= 1'b0;
            batch_len  <= '0;
            if ((state == LOAD) && close_batch) begin
                drain      <= DW'(FLUSH_CYCLES);
                sort_flush <= 1'b0;
            end else if (state == DRAIN) begin
                if (drain_end) begin
                    sort_flush <= 1'b0;
                end else begin
                    sort_flush <= 1'b1;
                    drain      <= drain - 1'b1;
                    if (drain == DW'(1)) begin
                        batch_done <= 1'b1;
                        batch_len  <= cnt;
                    end
                end
            end else begin
                sort_flush <= 1'b0;
            end
        end
    end

endmodule
